// File: rtl/irq_timer_pkg.sv
// Shared types and constants for the irq_timer_bank timer block.
// Holds the per-channel FSM state encoding and the irq vector width.
package irq_timer_pkg;

  localparam int unsigned IrqW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } ch_state_e;

endpackage

// File: rtl/irq_timer_ch.sv
// One timer channel: FSM, down-counter, pending flag and optional overrun flag.
// Overrun logic exists only when IRQ_TIMER_OVERRUN_EN is defined; otherwise overrun is 0.
module irq_timer_ch
  import irq_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic             ack,
  output logic             pending,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             oneshot_q, oneshot_d;
  logic             pending_q, pending_d;
  logic             expire;

  assign expire = (state_q == StRun) && !halt && (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    oneshot_d = oneshot_q;
    if ((state_q == StRun) && !halt) begin
      if (expire) begin
        if (oneshot_q) begin
          state_d = StDone;
        end else begin
          cnt_d = period_q - CntOne;
        end
      end else begin
        cnt_d = cnt_q - CntOne;
      end
    end
    // A write overrides the counting update, but the expiry above still reaches pending.
    if (cfg_we) begin
      period_d  = cfg_period;
      oneshot_d = cfg_oneshot;
      if (cfg_period != '0) begin
        state_d = StRun;
        cnt_d   = cfg_period - CntOne;
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end
  end

  assign pending_d = expire || (pending_q && !ack);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      period_q  <= '0;
      oneshot_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      oneshot_q <= oneshot_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

`ifdef IRQ_TIMER_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Ack clears overrun even when an expiry lands on the same edge.
  assign overrun_d = !ack && (overrun_q || (expire && pending_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: rtl/irq_timer_bank.sv
// Bank of NUM_CH independent interval timers driving a picorv32-style irq vector.
// Define IRQ_TIMER_OVERRUN_EN to build the per-channel overrun flags.
module irq_timer_bank
  import irq_timer_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned IRQ_BASE = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              halt_i,
  input  logic              cfg_we_i,
  input  logic [3:0]        cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_period_i,
  input  logic              cfg_oneshot_i,
  input  logic [NUM_CH-1:0] irq_ack_i,
  output logic [IrqW-1:0]   irq_o,
  output logic [NUM_CH-1:0] pending_o,
  output logic [NUM_CH-1:0] overrun_o
);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic ch_we;

    // Writes to channel indices beyond NUM_CH match no instance and are dropped.
    assign ch_we = cfg_we_i && (cfg_ch_i == 4'(n));

    irq_timer_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (clk_i),
      .rst_n       (rst_n_i),
      .halt        (halt_i),
      .cfg_we      (ch_we),
      .cfg_period  (cfg_period_i),
      .cfg_oneshot (cfg_oneshot_i),
      .ack         (irq_ack_i[n]),
      .pending     (pending_o[n]),
      .overrun     (overrun_o[n])
    );
  end

  always_comb begin
    irq_o = '0;
    irq_o[IRQ_BASE +: NUM_CH] = pending_o;
  end

endmodule

// File: tb/tb_irq_timer_bank.sv
// Self-checking bench for irq_timer_bank: directed vector table plus multi-cycle sequences.
// Overrun expectations follow IRQ_TIMER_OVERRUN_EN.
module tb_irq_timer_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        we;
  logic [3:0]  ch;
  logic [15:0] period;
  logic        oneshot;
  logic [1:0]  ack;
  logic [31:0] irq;
  logic [1:0]  pend;
  logic [1:0]  ovr;

`ifdef IRQ_TIMER_OVERRUN_EN
  localparam logic [1:0] OvMask = 2'b11;
`else
  localparam logic [1:0] OvMask = 2'b00;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irq_timer_bank dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .halt_i        (halt),
    .cfg_we_i      (we),
    .cfg_ch_i      (ch),
    .cfg_period_i  (period),
    .cfg_oneshot_i (oneshot),
    .irq_ack_i     (ack),
    .irq_o         (irq),
    .pending_o     (pend),
    .overrun_o     (ovr)
  );

  typedef struct packed {
    logic        we;
    logic [3:0]  ch;
    logic [15:0] period;
    logic        os;
    logic [1:0]  ack;
    logic        halt;
    logic [1:0]  ep;
    logic [1:0]  eo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic w, input logic [3:0] c, input logic [15:0] p, input logic os,
                     input logic [1:0] a, input logic h, input logic [1:0] ep,
                     input logic [1:0] eo);
    vec_t v;
    v = '{we: w, ch: c, period: p, os: os, ack: a, halt: h, ep: ep, eo: eo};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [1:0] ep, input logic [1:0] eo);
    check({name, "_pend"}, {30'd0, pend}, {30'd0, ep});
    check({name, "_ovr"}, {30'd0, ovr}, {30'd0, eo & OvMask});
    check({name, "_irq"}, irq, {26'd0, ep, 4'd0});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] c, input logic [15:0] p, input logic os);
    we = 1'b1;
    ch = c;
    period = p;
    oneshot = os;
    tick();
    we = 1'b0;
  endtask

  initial begin
    int seen;
    int n0, n1;
    int r0[2];
    int r1;

    rst_n = 1'b0; halt = 1'b0; we = 1'b0; ch = '0; period = '0; oneshot = 1'b0; ack = '0;
    repeat (3) tick();
    check_outs("reset", 2'b00, 2'b00);
    rst_n = 1'b1;

    // we, ch, P, oneshot, ack, halt, expected pending, expected overrun
    add(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
    add(1, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00);
    add(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
    add(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01);
    add(0, 0, 0, 0, 2'b01, 0, 2'b01, 2'b00);
    add(1, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01);
    add(0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00);
    add(1, 7, 1, 0, 2'b00, 0, 2'b00, 2'b00);
    add(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
    add(1, 1, 2, 1, 2'b00, 0, 2'b00, 2'b00);
    add(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
    add(0, 0, 0, 0, 2'b00, 0, 2'b10, 2'b00);
    add(0, 0, 0, 0, 2'b00, 0, 2'b10, 2'b00);
    add(0, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00);
    add(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
    add(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
    add(1, 0, 2, 0, 2'b00, 0, 2'b00, 2'b00);
    add(1, 1, 1, 0, 2'b00, 0, 2'b00, 2'b00);
    add(0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00);
    add(0, 0, 0, 0, 2'b11, 0, 2'b10, 2'b00);
    add(0, 0, 0, 0, 2'b01, 0, 2'b11, 2'b10);
    add(1, 1, 0, 0, 2'b11, 0, 2'b10, 2'b00);
    add(1, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00);
    add(0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00);
    add(1, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00);
    add(1, 0, 3, 0, 2'b00, 0, 2'b01, 2'b00);
    add(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
    add(0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00);
    add(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
    add(1, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00);
    add(1, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00);
    add(0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00);
    add(1, 0, 2, 0, 2'b00, 1, 2'b00, 2'b00);
    add(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
    add(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
    add(1, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00);

    foreach (vecs[i]) begin
      we = vecs[i].we; ch = vecs[i].ch; period = vecs[i].period; oneshot = vecs[i].os;
      ack = vecs[i].ack; halt = vecs[i].halt;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].ep, vecs[i].eo);
    end
    we = 1'b0; ack = '0; halt = 1'b0;

    // One-shot P=5, acked two cycles after firing.
    wr(0, 5, 1);
    repeat (4) tick();
    check_outs("os_before", 2'b00, 2'b00);
    tick();
    check_outs("os_fire", 2'b01, 2'b00);
    tick();
    check_outs("os_hold", 2'b01, 2'b00);
    ack = 2'b01; tick(); ack = 2'b00;
    check_outs("os_ack", 2'b00, 2'b00);
    seen = 0;
    repeat (20) begin
      tick();
      if (pend != 2'b00) seen++;
    end
    check("os_never_again", seen, 0);

    // Periodic P=3 left unacked, then ack, then ack on an expiry edge.
    wr(0, 3, 0);
    repeat (3) tick();
    check_outs("ovr_first", 2'b01, 2'b00);
    repeat (3) tick();
    check_outs("ovr_second", 2'b01, 2'b01);
    ack = 2'b01; tick(); ack = 2'b00;
    check_outs("ovr_ack", 2'b00, 2'b00);
    tick();
    ack = 2'b01; tick();
    check_outs("ovr_ack_exp", 2'b01, 2'b00);
    wr(0, 0, 0); ack = 2'b00;
    check_outs("ovr_stop", 2'b00, 2'b00);

    // Write coinciding with expiry, then halt for 20 cycles at count 4.
    wr(0, 1, 0);
    wr(0, 10, 0);
    check_outs("wr_exp_pend", 2'b01, 2'b00);
    repeat (5) tick();
    halt = 1'b1;
    repeat (4) tick();
    ack = 2'b01; tick(); ack = 2'b00;
    check_outs("halt_ack", 2'b00, 2'b00);
    repeat (15) tick();
    halt = 1'b0;
    check_outs("halt_frozen", 2'b00, 2'b00);
    repeat (4) tick();
    check_outs("halt_pre", 2'b00, 2'b00);
    tick();
    check_outs("halt_fire", 2'b01, 2'b00);
    ack = 2'b01; wr(0, 0, 0); ack = 2'b00;
    check_outs("halt_stop", 2'b00, 2'b00);

    // Disable while pending: pending retained, no further expiry.
    wr(0, 4, 0);
    repeat (4) tick();
    check_outs("dis_fire", 2'b01, 2'b00);
    wr(0, 0, 0);
    repeat (20) tick();
    check_outs("dis_retain", 2'b01, 2'b00);
    ack = 2'b01; tick(); ack = 2'b00;
    check_outs("dis_ack", 2'b00, 2'b00);

    // Long periods on both channels, acking every rise.
    n0 = 0; n1 = 0; r0[0] = 0; r0[1] = 0; r1 = 0;
    wr(0, 16'd8192, 0);
    wr(1, 16'd20000, 0);
    for (int k = 2; k <= 20010; k++) begin
      ack = pend;
      tick();
      if (pend[0]) begin
        if (n0 < 2) r0[n0] = k;
        n0++;
      end
      if (pend[1]) begin
        if (n1 == 0) r1 = k;
        n1++;
      end
    end
    ack = 2'b00;
    check("long_ch0_first", r0[0], 8192);
    check("long_ch0_second", r0[1], 16384);
    check("long_ch0_count", n0, 2);
    check("long_ch1_first", r1, 20001);
    check("long_ch1_count", n1, 1);
    wr(0, 0, 0);
    wr(1, 0, 0);
    ack = 2'b11; tick(); ack = 2'b00;

    // Reset mid-count with every other input active.
    wr(0, 1, 0);
    tick();
    wr(1, 100, 0);
    repeat (49) tick();
    check("rst_pre_pend", {30'd0, pend}, 32'h1);
    rst_n = 1'b0; we = 1'b1; ch = 4'd0; period = 16'd1; ack = 2'b11; halt = 1'b1;
    tick();
    check_outs("rst_mid", 2'b00, 2'b00);
    rst_n = 1'b1; we = 1'b0; ack = 2'b00; halt = 1'b0;
    seen = 0;
    repeat (200) begin
      tick();
      if (irq != 32'd0 || pend != 2'b00 || ovr != 2'b00) seen++;
    end
    check("rst_quiet", seen, 0);
    wr(7, 1, 0);
    repeat (5) tick();
    check_outs("bad_ch", 2'b00, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
